// File: rtl/uart_frame_rx.sv
// uart_frame_rx: SOF/length/checksum framed-packet receiver that releases only verified payloads.
// Define UART_FRAME_TIMEOUT_EN to abort frames that stall for TIMEOUT_CYCLES between bytes.
module uart_frame_rx #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SOF            = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1_250_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX_L = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, DRAIN} state_t;
    state_t state_q, state_d;

    logic [7:0]    buf_q [MAX_LEN];
    logic [7:0]    len_q, len_d, sum_q, sum_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          acc, busy, at_last, bad_len, sum_ok, drain_hs, tmo_hit;

    assign in_ready  = state_q != DRAIN;
    assign acc       = in_valid && in_ready;
    assign busy      = state_q inside {LEN, PAYLOAD, CSUM};
    assign at_last   = 8'(idx_q) == len_q - 8'd1;
    assign bad_len   = in_data == 8'd0 || in_data > MAX_L;
    assign sum_ok    = (sum_q + in_data) == 8'd0;
    assign out_valid = state_q == DRAIN;
    assign drain_hs  = out_valid && out_ready;
    assign out_last  = out_valid && at_last;
    assign out_data  = out_valid ? buf_q[idx_q] : 8'h00;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;
    // Counts consecutive idle cycles inside a frame; any accepted byte restarts it.
    assign tmo_hit = busy && !acc && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tmo_q <= '0;
        else        tmo_q <= (busy && !acc) ? tmo_q + TW'(1) : '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc && in_data == SOF) state_d = LEN;
            LEN:     if (acc) state_d = bad_len ? IDLE : PAYLOAD;
            PAYLOAD: if (acc && at_last) state_d = CSUM;
            CSUM:    if (acc) state_d = sum_ok ? DRAIN : IDLE;
            DRAIN:   if (drain_hs && at_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (tmo_hit) state_d = IDLE;
    end

    always_comb begin
        len_d       = len_q;
        sum_d       = sum_q;
        idx_d       = idx_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        case (state_q)
            LEN: if (acc) begin
                if (bad_len) begin
                    frame_err_d = 1'b1;
                    err_code_d  = 2'd1;
                end else begin
                    len_d = in_data;
                    sum_d = in_data;
                    idx_d = '0;
                end
            end
            PAYLOAD: if (acc) begin
                sum_d = sum_q + in_data;
                idx_d = idx_q + IW'(1);
            end
            CSUM: if (acc) begin
                frame_ok_d  = sum_ok;
                frame_err_d = !sum_ok;
                idx_d       = '0;
                if (!sum_ok) err_code_d = 2'd2;
            end
            DRAIN: if (drain_hs) idx_d = at_last ? '0 : idx_q + IW'(1);
            default: ;
        endcase
        if (tmo_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= 2'd0;
        end else begin
            len_q       <= len_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
        end
    end

    // Payload storage needs no reset: it is only read back after a full frame has been written.
    always_ff @(posedge clk) begin
        if (state_q == PAYLOAD && acc) buf_q[idx_q] <= in_data;
    end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: randomized frame stream checked against a frame-level reference model.
module tb_uart_frame_rx;
    localparam int MAX_LEN = 16;
    localparam logic [7:0] SOF = 8'hA5;
`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TMO = 100;
`else
    localparam int TMO = 1_250_000;
`endif

    logic       clk = 1'b0, reset = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0, out_ready = 1'b1;
    logic       in_ready, out_valid, out_last, frame_ok, frame_err;
    logic [7:0] out_data;
    logic [1:0] err_code;

    int errors = 0, checks = 0;
    int ok_cnt = 0, err_cnt = 0;
    logic [1:0] model_code = 2'd0;
    logic [1:0] rdy_mode = 2'd0;
    logic [8:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic       stalled = 1'b0;
    logic [8:0] held = 9'h0;

    uart_frame_rx #(.MAX_LEN(MAX_LEN), .SOF(SOF), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output-side monitor: drives out_ready, scoreboards drained bytes, counts flag pulses.
    always @(negedge clk) begin
        if (!reset) stalled = 1'b0;
        else begin
            out_ready = rdy_mode == 2'd0 ? 1'b1 : rdy_mode == 2'd1 ? 1'($urandom_range(0, 1)) :
                        rdy_mode == 2'd2 ? !out_ready : 1'b0;
            if (stalled) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_last, out_data}), 32'(held));
            end
            if (out_valid) check("in_ready_drain", 32'(in_ready), 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("out_unexpected", 32'(out_valid), 32'd0);
                else check("out_byte", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
            end
            stalled = out_valid && !out_ready;
            held = {out_last, out_data};
            if (frame_ok) ok_cnt++;
            if (frame_err) err_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic mk_good(input int l);
        logic [7:0] s, b;
        tx_q.delete();
        tx_q.push_back(SOF);
        tx_q.push_back(8'(l));
        s = 8'(l);
        for (int i = 0; i < l; i++) begin
            b = ($urandom_range(0, 4) == 0) ? SOF : 8'($urandom);
            tx_q.push_back(b);
            s += b;
        end
        tx_q.push_back(8'd0 - s);
    endtask

    // Reference model: classify the whole frame from the framing rules, then send and compare.
    task automatic run_frame();
        int l, ok0, er0, n;
        logic [7:0] s;
        bit want_ok, want_err, framed;
        want_ok = 1'b0;
        want_err = 1'b0;
        framed = tx_q[0] == SOF;
        if (framed) begin
            l = int'(tx_q[1]);
            if (l == 0 || l > MAX_LEN) begin
                want_err = 1'b1;
                model_code = 2'd1;
            end else begin
                s = 8'd0;
                for (int i = 1; i <= l + 2; i++) s += tx_q[i];
                want_ok = s == 8'd0;
                want_err = !want_ok;
                if (want_err) model_code = 2'd2;
                else for (int i = 0; i < l; i++) exp_q.push_back({i == l - 1, tx_q[i + 2]});
            end
        end
        ok0 = ok_cnt;
        er0 = err_cnt;
        foreach (tx_q[i]) send_byte(tx_q[i]);
        if (framed) begin
            check("frame_ok", 32'(frame_ok), 32'(want_ok));
            check("frame_err", 32'(frame_err), 32'(want_err));
            check("first_valid", 32'(out_valid), 32'(want_ok));
        end
        n = 0;
        while (exp_q.size() > 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("ok_pulses", 32'(ok_cnt - ok0), 32'(want_ok));
        check("err_pulses", 32'(err_cnt - er0), 32'(want_err));
        check("err_code", 32'(err_code), 32'(model_code));
        check("in_ready_idle", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_vals();
        exp_q.delete();
        model_code = 2'd0;
        @(negedge clk);
        reset = 1'b1;
        rdy_mode = 2'd0;
    endtask

    initial begin
        int kind, l;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        @(negedge clk);
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        run_frame();
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        run_frame();
        tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        run_frame();
        tx_q = '{8'hA5, 8'h00};
        run_frame();
        tx_q = '{SOF, 8'(MAX_LEN + 1)};
        run_frame();
        rdy_mode = 2'd2;
        mk_good(MAX_LEN);
        run_frame();
        rdy_mode = 2'd0;
        tx_q = '{8'h00, 8'hFF, 8'h5A};
        run_frame();
        tx_q = '{8'hA5, 8'h01, 8'h7E, 8'h81};
        run_frame();
        for (int f = 0; f < 150; f++) begin
            kind = $urandom_range(0, 3);
            rdy_mode = 2'($urandom_range(0, 2));
            l = $urandom_range(1, MAX_LEN);
            if (kind == 0) mk_good(l);
            else if (kind == 1) begin
                mk_good(l);
                tx_q[tx_q.size() - 1] += 8'($urandom_range(1, 255));
            end else if (kind == 2) begin
                tx_q.delete();
                tx_q.push_back(SOF);
                tx_q.push_back($urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                tx_q.delete();
                repeat ($urandom_range(1, 4)) tx_q.push_back(8'($urandom_range(0, 8'hA4)));
            end
            run_frame();
        end
        rdy_mode = 2'd0;
        tx_q = '{8'hA5, 8'h05, 8'h11, 8'h22};
        foreach (tx_q[i]) send_byte(tx_q[i]);
        pulse_reset();
        mk_good(4);
        run_frame();
        rdy_mode = 2'd3;
        mk_good(4);
        foreach (tx_q[i]) send_byte(tx_q[i]);
        repeat (3) @(negedge clk);
        check("drain_stalled", 32'(out_valid), 32'd1);
        pulse_reset();
        mk_good(3);
        run_frame();
`ifdef UART_FRAME_TIMEOUT_EN
        begin
            int n;
            tx_q = '{8'hA5, 8'h02, 8'h11};
            foreach (tx_q[i]) send_byte(tx_q[i]);
            n = 0;
            while (!frame_err && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("tmo_cycles", 32'(n), 32'd100);
            check("tmo_code", 32'(err_code), 32'd3);
            model_code = 2'd3;
            mk_good(2);
            run_frame();
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Framed-packet receiver sitting directly downstream of the UART wrapper's RX byte stream (DataOut / DataOut_valid / DataOut_ready). Hunts for a start-of-frame byte, reads a length byte, buffers up to MAX_LEN payload bytes and checks an 8-bit additive checksum. Only frames that pass are released, as a valid/ready byte stream with an end-of-frame marker; bad frames are dropped and flagged.

## Interface
- MAX_LEN, 16: maximum payload bytes per frame (1..255); sizes the internal buffer.
- SOF, 8'hA5: start-of-frame byte value.
- TIMEOUT_CYCLES, 1_250_000: idle clocks allowed between bytes inside a frame (used only with UART_FRAME_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  RX byte from UART.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts on out_valid && out_ready.
- out_last  out  1  high with the final payload byte of a frame.
- frame_ok  out  1  one-cycle pulse: frame passed check.
- frame_err  out  1  one-cycle pulse: frame dropped.
- err_code  out  2  cause of last drop: 1 bad length, 2 bad checksum, 3 timeout; holds until next frame_err.

## Operation
- States: IDLE, LEN, PAYLOAD, CSUM, DRAIN.
- IDLE: accept bytes; byte == SOF -> LEN; any other byte discarded silently, no flags.
- LEN: accepted byte L. L == 0 or L > MAX_LEN -> frame_err, err_code=1, IDLE. Else store L, sum <= L, index <= 0, -> PAYLOAD.
- PAYLOAD: each accepted byte written to buffer[index], sum <= sum + byte (mod 256), index++. After L-th byte -> CSUM.
- CSUM: accepted byte C. (sum + C) mod 256 == 0 -> frame_ok, -> DRAIN. Else frame_err, err_code=2, -> IDLE.
- DRAIN: buffer[0..L-1] presented in order; out_last with byte L-1. Handshake on last byte -> IDLE.
- in_ready = 1 in IDLE/LEN/PAYLOAD/CSUM, 0 in DRAIN (back-pressure held on UART; no bytes lost).
- A SOF value inside LEN/PAYLOAD/CSUM is treated as data, not a resync.
- Buffer index width $clog2(MAX_LEN); sum is 8 bits, wraps.

## Timing
- Reset (asserted, async): state IDLE, in_ready 1, out_valid 0, out_data 8'h00, out_last 0, frame_ok 0, frame_err 0, err_code 0, sum/index/timeout counter 0. Reset mid-frame or mid-drain discards everything, no flags.
- frame_ok / frame_err registered: high exactly the cycle after the deciding byte's handshake.
- out_valid rises in the same cycle as frame_ok (1-cycle latency from checksum accept to first payload byte).
- Drain at 1 byte/cycle while out_ready high; out_data/out_last stable while out_valid && !out_ready; out_valid never drops before handshake.
- in_ready returns to 1 the cycle after the last-byte handshake.
- frame_err leaves state IDLE with in_ready 1 the next cycle; byte presented that cycle is a SOF candidate.

## Configuration
- UART_FRAME_TIMEOUT_EN defined: counter clears on every accepted byte and on entry to LEN; in LEN/PAYLOAD/CSUM, TIMEOUT_CYCLES consecutive cycles without an accepted byte -> frame_err, err_code=3, IDLE. Counter idle in IDLE and DRAIN.
- Not defined: no counter in RTL; an incomplete frame waits indefinitely; err_code 3 never produced.

## Test plan
- Good frame A5 03 11 22 33 97 (sum 0x69+0x97=0x100) -> frame_ok one pulse; out 11,22,33 with out_last on 33; err_code 0.
- Same frame with checksum 98 -> frame_err, err_code=2, no out_valid; following good frame received intact.
- Length 00 and length MAX_LEN+1 after A5 -> frame_err, err_code=1 each; in_ready stays 1.
- Good 16-byte frame, out_ready toggled 1/0 every cycle -> all 16 bytes in order, data stable when stalled, in_ready 0 throughout drain.
- Garbage 00 FF 5A then A5 01 7E 81 -> no flags for garbage, frame_ok, single byte 7E with out_last.
- With UART_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: send A5 02 11 then idle 100 cycles -> frame_err, err_code=3; reset asserted mid-frame -> all outputs at reset values, no flags.
